spike_scheduler: RTL and testbench

//  Per-core timestep scheduler between a ring router's scheduler output and its neuron core.

---
 rtl/spike_scheduler.sv | 118 +++++++++++
 tb/tb_spike_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_scheduler.sv
// Per-core timestep scheduler: files router spike packets into tick-indexed slot FIFOs
// by their delay field and drains the current slot to the neuron core on each tick.
module spike_scheduler #(
  parameter int PKT_W      = 34,
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PKT_W-1:0]             in_packet,
  input  logic                         tick,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PKT_W-1:0]             out_packet,
  output logic [$clog2(NUM_SLOTS)-1:0] cur_slot,
  output logic                         busy,
  output logic                         tick_overrun,
  output logic [15:0]                  drop_count
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int PW = $clog2(SLOT_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           state;
  logic             pending;
  logic [CW-1:0]    count  [NUM_SLOTS];
  logic [PW-1:0]    wr_ptr [NUM_SLOTS];
  logic [PW-1:0]    rd_ptr [NUM_SLOTS];
  logic [PKT_W-1:0] mem    [NUM_SLOTS][SLOT_DEPTH];

  logic [1:0]           dly;
  logic [SW-1:0]        de;
  logic [SW-1:0]        target;
  logic                 tgt_full;
  logic                 enq;
  logic                 drop;
  logic                 deq;
  logic [NUM_SLOTS-1:0] enq_sel;
  logic [NUM_SLOTS-1:0] deq_sel;

  // Delay is clamped so a packet can never land in the slot that is being drained.
  always_comb begin
    dly = in_packet[PKT_W-3 -: 2];
    if (int'(dly) > NUM_SLOTS - 2)
      de = SW'(NUM_SLOTS - 2);
    else
      de = SW'(dly);
    target   = cur_slot + SW'(1) + de;
    tgt_full = (count[target] == CW'(SLOT_DEPTH));
    enq      = in_valid && in_ready && !tgt_full;
    drop     = in_valid && in_ready && tgt_full;
    deq      = out_valid && out_ready;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      enq_sel[s] = enq && (target == SW'(s));
      deq_sel[s] = deq && (cur_slot == SW'(s));
    end
  end

  assign out_valid  = (state == DRAIN) && (count[cur_slot] != '0);
  assign out_packet = mem[cur_slot][rd_ptr[cur_slot]];
  assign busy       = (state == DRAIN) || pending;

  always_ff @(posedge clk) begin
    if (enq)
      mem[target][wr_ptr[target]] <= in_packet;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        count[s]  <= '0;
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
      end
      state        <= IDLE;
      cur_slot     <= '0;
      pending      <= 1'b0;
      tick_overrun <= 1'b0;
      drop_count   <= '0;
      in_ready     <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (enq_sel[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
        if (deq_sel[s]) rd_ptr[s] <= rd_ptr[s] + PW'(1);
        count[s] <= count[s] + {{(CW-1){1'b0}}, enq_sel[s]} - {{(CW-1){1'b0}}, deq_sel[s]};
      end
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;

      // A pending tick left over from a drain is replayed as a tick in IDLE.
      case (state)
        IDLE: begin
          if (tick || pending) begin
            cur_slot <= cur_slot + SW'(1);
            state    <= DRAIN;
            pending  <= 1'b0;
            if (tick && pending) tick_overrun <= 1'b1;
          end
        end
        DRAIN: begin
          if (count[cur_slot] == '0) state <= IDLE;
          if (tick) begin
            if (pending) tick_overrun <= 1'b1;
            else         pending      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_scheduler.sv
// Directed self-checking bench for spike_scheduler: a table of single-cycle vectors
// plus hand-written sequences for overflow, overrun and mid-drain reset.
module tb_spike_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] in_packet;
  logic        tick;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_packet;
  logic [1:0]  cur_slot;
  logic        busy;
  logic        tick_overrun;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  spike_scheduler #(.PKT_W(34), .NUM_SLOTS(4), .SLOT_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
    .tick(tick), .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet),
    .cur_slot(cur_slot), .busy(busy), .tick_overrun(tick_overrun), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_before;
    logic        vin;
    logic [33:0] pkt;
    logic        tck;
    logic        ordy;
    logic        exp_ov;
    logic [33:0] exp_pkt;
    logic [1:0]  exp_cur;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [33:0] mk(logic [1:0] dest, logic [1:0] d, logic [29:0] pay);
    return {dest, d, pay};
  endfunction

  function automatic vec_t mkv(logic rb, logic vin, logic [33:0] pkt, logic tck, logic ordy,
                               logic ov, logic [33:0] opkt, logic [1:0] cur, logic bsy);
    vec_t v;
    v.rst_before = rb; v.vin = vin; v.pkt = pkt; v.tck = tck; v.ordy = ordy;
    v.exp_ov = ov; v.exp_pkt = opkt; v.exp_cur = cur; v.exp_busy = bsy;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b0; in_valid = 1'b0; in_packet = '0; tick = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic enqueue(logic [33:0] pkt);
    in_valid = 1'b1; in_packet = pkt;
    step();
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(vec_t v, int idx);
    if (v.rst_before) doReset();
    in_valid = v.vin; in_packet = v.pkt; tick = v.tck; out_ready = v.ordy;
    step();
    in_valid = 1'b0; tick = 1'b0;
    checkOutput($sformatf("vec%0d out_valid", idx), 64'(out_valid), 64'(v.exp_ov));
    checkOutput($sformatf("vec%0d cur_slot", idx), 64'(cur_slot), 64'(v.exp_cur));
    checkOutput($sformatf("vec%0d busy", idx), 64'(busy), 64'(v.exp_busy));
    if (v.exp_ov)
      checkOutput($sformatf("vec%0d out_packet", idx), 64'(out_packet), 64'(v.exp_pkt));
  endtask

  initial begin
    logic [33:0] p1, p2, p5, p6, p7, p8;
    logic [33:0] burst [9];

    p1 = mk(2'd0, 2'd0, 30'hAA);
    p2 = mk(2'd2, 2'd2, 30'h155);
    p5 = mk(2'd1, 2'd3, 30'h3FFF0001);
    p6 = mk(2'd3, 2'd0, 30'h12345);
    p7 = mk(2'd1, 2'd0, 30'h777);
    p8 = mk(2'd2, 2'd0, 30'h888);

    // Basic delivery: d=0 lands in the next slot and appears right after the tick edge.
    vecs.push_back(mkv(1, 1, p1, 0, 0, 0, '0, 2'd0, 0));
    vecs.push_back(mkv(0, 0, '0, 1, 1, 1, p1, 2'd1, 1));
    vecs.push_back(mkv(0, 0, '0, 0, 1, 0, '0, 2'd1, 1));
    vecs.push_back(mkv(0, 0, '0, 0, 1, 0, '0, 2'd1, 0));
    // d=2 and clamped d=3 both wait for the third tick.
    foreach (vecs[i]) begin end
    for (int g = 0; g < 2; g++) begin
      logic [33:0] p;
      p = (g == 0) ? p2 : p5;
      vecs.push_back(mkv(1, 1, p,  0, 1, 0, '0, 2'd0, 0));
      vecs.push_back(mkv(0, 0, '0, 1, 1, 0, '0, 2'd1, 1));
      vecs.push_back(mkv(0, 0, '0, 0, 1, 0, '0, 2'd1, 0));
      vecs.push_back(mkv(0, 0, '0, 1, 1, 0, '0, 2'd2, 1));
      vecs.push_back(mkv(0, 0, '0, 0, 1, 0, '0, 2'd2, 0));
      vecs.push_back(mkv(0, 0, '0, 1, 1, 1, p,  2'd3, 1));
      vecs.push_back(mkv(0, 0, '0, 0, 1, 0, '0, 2'd3, 1));
      vecs.push_back(mkv(0, 0, '0, 0, 1, 0, '0, 2'd3, 0));
    end
    // Enqueue in the same cycle as the tick lands in the new current slot.
    vecs.push_back(mkv(1, 1, p6, 1, 1, 1, p6, 2'd1, 1));
    vecs.push_back(mkv(0, 0, '0, 0, 1, 0, '0, 2'd1, 1));
    vecs.push_back(mkv(0, 0, '0, 0, 1, 0, '0, 2'd1, 0));
    // Enqueue to another slot while dequeuing from the current one.
    vecs.push_back(mkv(1, 1, p7, 0, 0, 0, '0, 2'd0, 0));
    vecs.push_back(mkv(0, 0, '0, 1, 0, 1, p7, 2'd1, 1));
    vecs.push_back(mkv(0, 1, p8, 0, 1, 0, '0, 2'd1, 1));
    vecs.push_back(mkv(0, 0, '0, 0, 1, 0, '0, 2'd1, 0));
    vecs.push_back(mkv(0, 0, '0, 1, 1, 1, p8, 2'd2, 1));
    vecs.push_back(mkv(0, 0, '0, 0, 1, 0, '0, 2'd2, 1));
    vecs.push_back(mkv(0, 0, '0, 0, 1, 0, '0, 2'd2, 0));

    // Reset state.
    rst = 1'b0; in_valid = 1'b0; in_packet = '0; tick = 1'b0; out_ready = 1'b0;
    step();
    checkOutput("reset in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset cur_slot", 64'(cur_slot), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset tick_overrun", 64'(tick_overrun), 64'd0);
    checkOutput("reset drop_count", 64'(drop_count), 64'd0);
    rst = 1'b1;
    step();
    checkOutput("in_ready after reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Slot overflow: ninth packet is dropped, first eight drain in order.
    doReset();
    for (int i = 0; i < 9; i++) begin
      burst[i] = mk(2'(i), 2'd0, 30'(32'h100 + i));
      enqueue(burst[i]);
    end
    checkOutput("overflow drop_count", 64'(drop_count), 64'd1);
    tick = 1'b1; out_ready = 1'b1;
    step();
    tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("overflow valid%0d", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("overflow pkt%0d", i), 64'(out_packet), 64'(burst[i]));
      step();
    end
    checkOutput("overflow ninth absent", 64'(out_valid), 64'd0);
    step();
    checkOutput("overflow busy done", 64'(busy), 64'd0);

    // Ticks during a stalled drain: one pends, the next is an overrun.
    doReset();
    for (int i = 0; i < 8; i++) begin
      burst[i] = mk(2'd1, 2'd0, 30'(32'h200 + i));
      enqueue(burst[i]);
    end
    tick = 1'b1;
    step();
    checkOutput("stall drain entered", 64'(out_valid), 64'd1);
    step();
    checkOutput("stall overrun clear", 64'(tick_overrun), 64'd0);
    step();
    tick = 1'b0;
    checkOutput("stall overrun set", 64'(tick_overrun), 64'd1);
    checkOutput("stall cur_slot", 64'(cur_slot), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("stall pkt%0d", i), 64'(out_packet), 64'(burst[i]));
      step();
    end
    checkOutput("stall drained", 64'(out_valid), 64'd0);
    step();
    checkOutput("stall pending busy", 64'(busy), 64'd1);
    step();
    checkOutput("stall auto advance", 64'(cur_slot), 64'd2);
    step();
    checkOutput("stall busy drop", 64'(busy), 64'd0);
    checkOutput("stall overrun sticky", 64'(tick_overrun), 64'd1);

    // Reset in the middle of a drain discards everything.
    doReset();
    for (int i = 0; i < 6; i++) enqueue(mk(2'd0, 2'd0, 30'(32'h300 + i)));
    tick = 1'b1;
    step();
    tick = 1'b0; out_ready = 1'b1;
    step();
    step();
    checkOutput("midreset valid before", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset out_valid async", 64'(out_valid), 64'd0);
    checkOutput("midreset in_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b1;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    checkOutput("midreset cur_slot", 64'(cur_slot), 64'd1);
    checkOutput("midreset no packet", 64'(out_valid), 64'd0);
    step();
    checkOutput("midreset idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
